// File: rtl/cmos_video_tx.sv
// Boson-style parallel video transmitter. Pops 2-pixel words from an FWFT FIFO
// and emits registered vsync/hsync/valid/data, frames back-to-back while start is high.
module cmos_video_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 512,
    parameter int V_BLANK  = 1000
) (
    input  logic        cmos_clk_i,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        fifo_re,
    output logic [15:0] cmos_data_o,
    output logic        cmos_vsync_o,
    output logic        cmos_hsync_o,
    output logic        cmos_valid_o,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_count
);

    localparam int CMAX = (V_BLANK > H_ACTIVE) ? ((V_BLANK > H_BLANK) ? V_BLANK : H_BLANK)
                                               : ((H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK);
    localparam int CW = $clog2(CMAX + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_VBLANK = 5'b00010;
    localparam logic [4:0] S_HBLANK = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_TAIL   = 5'b10000;

    logic [4:0]    state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [LW-1:0] line, nline;
    logic          frame_done;
    logic [15:0]   hold;

    assign busy = (state != S_IDLE);

    always_comb begin
        nstate     = state;
        ncnt       = cnt + 1'b1;
        nline      = line;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                ncnt = '0;
                if (start) nstate = S_VBLANK;
            end
            S_VBLANK: if (cnt == CW'(V_BLANK - 1)) begin
                nstate = S_HBLANK;
                ncnt   = '0;
                nline  = '0;
            end
            S_HBLANK: if (cnt == CW'(H_BLANK - 1)) begin
                nstate = S_ACTIVE;
                ncnt   = '0;
            end
            S_ACTIVE: if (cnt == CW'(H_ACTIVE - 1)) begin
                ncnt = '0;
                if (line < LW'(V_ACTIVE - 1)) begin
                    nline  = line + 1'b1;
                    nstate = S_HBLANK;
                end else begin
                    nstate = S_TAIL;
                end
            end
            S_TAIL: if (cnt == CW'(H_BLANK - 1)) begin
                frame_done = 1'b1;
                ncnt       = '0;
                nstate     = start ? S_VBLANK : S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
                ncnt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state.
    // fifo_re accompanies the even pixel; the FWFT head only advances a cycle later,
    // which is still before the next even-pixel fetch.
    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            line         <= '0;
            hold         <= '0;
            fifo_re      <= 1'b0;
            cmos_data_o  <= '0;
            cmos_vsync_o <= 1'b0;
            cmos_hsync_o <= 1'b0;
            cmos_valid_o <= 1'b0;
            underrun     <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= nstate;
            cnt          <= ncnt;
            line         <= nline;
            cmos_vsync_o <= (nstate == S_HBLANK) || (nstate == S_ACTIVE) || (nstate == S_TAIL);
            cmos_hsync_o <= (nstate == S_ACTIVE);
            cmos_valid_o <= (nstate == S_ACTIVE);
            fifo_re      <= 1'b0;
            cmos_data_o  <= '0;
            if (nstate == S_ACTIVE) begin
                if (!ncnt[0]) begin
                    if (!fifo_empty_i) begin
                        cmos_data_o <= fifo_data_i[15:0];
                        hold        <= fifo_data_i[31:16];
                        fifo_re     <= 1'b1;
                    end else begin
                        hold     <= '0;
                        underrun <= 1'b1;
                    end
                end else begin
                    cmos_data_o <= hold;
                end
            end
            if (frame_done) frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_video_tx.sv
// Directed bench for cmos_video_tx with a small FWFT FIFO model; 4x2 frame, 17-cycle period.
module tb_cmos_video_tx;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] fifo_data_i;
    logic        fifo_empty_i, fifo_re;
    logic [15:0] cmos_data_o;
    logic        cmos_vsync_o, cmos_hsync_o, cmos_valid_o;
    logic        busy, underrun;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:31];
    int          rd, wr, pops;
    logic        fifo_clr, empty_ovr;

    cmos_video_tx #(.H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .V_BLANK(3)) dut (
        .cmos_clk_i  (clk),
        .rst         (rst),
        .start       (start),
        .fifo_data_i (fifo_data_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_re     (fifo_re),
        .cmos_data_o (cmos_data_o),
        .cmos_vsync_o(cmos_vsync_o),
        .cmos_hsync_o(cmos_hsync_o),
        .cmos_valid_o(cmos_valid_o),
        .busy        (busy),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    assign fifo_empty_i = (rd >= wr) || empty_ovr;
    assign fifo_data_i  = (rd < 32) ? mem[rd] : 32'h0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd   <= 0;
            pops <= 0;
        end else if (fifo_re && !fifo_empty_i) begin
            rd   <= rd + 1;
            pops <= pops + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return {12'h0, cmos_vsync_o, cmos_hsync_o, cmos_valid_o, fifo_re, cmos_data_o};
    endfunction

    function automatic logic [31:0] mk(logic vs, logic act, logic re, logic [15:0] d);
        return {12'h0, vs, act, act, re, d};
    endfunction

    // Hand-derived trace of the first frame after a start edge (k = cycles after that edge).
    function automatic logic [31:0] exp1(int k);
        logic        vs, act, re;
        logic [15:0] d;
        vs  = (k >= 3) && (k <= 16);
        act = ((k >= 5) && (k <= 8)) || ((k >= 11) && (k <= 14));
        re  = (k == 5) || (k == 7) || (k == 11) || (k == 13);
        d   = !act ? 16'h0 : (k <= 8) ? 16'(k - 4) : 16'(k - 6);
        return mk(vs, act, re, d);
    endfunction

    task automatic do_reset(input int fill);
        rst = 1'b1; fifo_clr = 1'b1; start = 1'b0; empty_ovr = 1'b0; wr = fill;
        tick(); tick();
        chk("reset_out", outv(), 32'h0);
        chk("reset_status", {busy, underrun, frame_count}, 32'h0);
        rst = 1'b0; fifo_clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {16'(2 * i + 2), 16'(2 * i + 1)};
        rst = 1'b1; start = 1'b0; fifo_clr = 1'b1; empty_ovr = 1'b0; wr = 0;

        // single-frame start pulse
        do_reset(4);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            chk($sformatf("frame1_k%0d", k), outv(), exp1(k));
            if (k == 16) chk("frame1_busy_tail", {31'h0, busy}, 32'h1);
            if (k < 17) tick();
        end
        chk("frame1_idle", {busy, underrun, frame_count}, 32'h1);
        chk("frame1_pops", pops, 4);

        // back-to-back frames
        do_reset(32);
        start = 1'b1; tick();
        for (int k = 0; k <= 34; k++) begin
            if (k == 16) chk("b2b_fc_k16", frame_count, 0);
            if (k == 17) chk("b2b_fc_k17", frame_count, 1);
            if (k == 17) chk("b2b_vs_k17", {31'h0, cmos_vsync_o}, 0);
            if (k == 19) chk("b2b_vs_k19", {31'h0, cmos_vsync_o}, 0);
            if (k == 20) chk("b2b_vs_k20", {31'h0, cmos_vsync_o}, 1);
            if (k == 22) chk("b2b_pix_k22", outv(), mk(1'b1, 1'b1, 1'b1, 16'd9));
            if (k == 33) chk("b2b_fc_k33", frame_count, 1);
            if (k == 34) chk("b2b_fc_k34", frame_count, 2);
            if (k < 34) tick();
        end
        start = 1'b0;

        // underrun on second word of line 0
        do_reset(4);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        empty_ovr = 1'b1; tick();
        chk("ur_k7", outv(), mk(1'b1, 1'b1, 1'b0, 16'h0));
        chk("ur_flag_k7", {31'h0, underrun}, 1);
        empty_ovr = 1'b0; tick();
        chk("ur_k8", outv(), mk(1'b1, 1'b1, 1'b0, 16'h0));
        tick(); tick(); tick();
        chk("ur_k11", outv(), mk(1'b1, 1'b1, 1'b1, 16'd3));
        tick();
        chk("ur_k12", outv(), mk(1'b1, 1'b1, 1'b0, 16'd4));
        tick();
        chk("ur_k13", outv(), mk(1'b1, 1'b1, 1'b1, 16'd5));
        for (int k = 13; k < 17; k++) tick();
        chk("ur_end", {busy, underrun, frame_count}, {1'b0, 1'b1, 16'd1});
        chk("ur_pops", pops, 3);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 17; k++) tick();
        chk("ur_sticky", {busy, underrun, frame_count}, {1'b0, 1'b1, 16'd2});

        // reset mid-line, then restart
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("rstmid_active", {31'h0, cmos_valid_o}, 1);
        rst = 1'b1; tick();
        chk("rstmid_out", outv(), 32'h0);
        chk("rstmid_status", {busy, underrun, frame_count}, 32'h0);
        rst = 1'b0; start = 1'b1; tick();
        chk("restart_k0", {busy, cmos_vsync_o}, 32'h2);
        tick(); tick();
        chk("restart_k2", {31'h0, cmos_vsync_o}, 0);
        tick();
        chk("restart_k3", {31'h0, cmos_vsync_o}, 1);
        start = 1'b0;
        for (int k = 3; k < 17; k++) tick();
        chk("restart_done", {busy, frame_count}, 32'h1);

        // start dropped in line 0, frame_count wrap
        do_reset(32);
        start = 1'b1; tick();
        for (int k = 0; k < 6; k++) tick();
        start = 1'b0;
        for (int k = 6; k < 10; k++) tick();
        force dut.frame_count = 16'hFFFF;
        tick();
        release dut.frame_count;
        for (int k = 11; k < 16; k++) tick();
        chk("drop_busy_k16", {busy, frame_count}, {1'b1, 16'hFFFF});
        tick();
        chk("drop_idle_k17", {busy, cmos_vsync_o, frame_count}, 32'h0);
        tick();
        chk("drop_stay_idle", {31'h0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
